bht_update_ctrl: RTL and testbench

- Scheduler for the single write (shift-in) port of the 1024x10 local branch history table.
- Accepts up to two committed branch outcomes per cycle from retire and queues them in program order. Issues at most one history shift per cycle.
- Also sequences a full-table clear by walking every entry and shifting in zeros.
- Sits between the retire stage and the BHT write port in the fetch unit.

---
 rtl/bht_update_ctrl_pkg.sv | 28 ++
 rtl/bht_upd_fifo.sv | 57 +++++
 rtl/bht_update_ctrl.sv | 145 ++++++++++++++
 tb/tb_bht_update_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/bht_update_ctrl_pkg.sv
// Shared fetch-side definitions for the local branch history table update path:
// table geometry, update-controller FSM states and the queued commit record.
package bht_update_ctrl_pkg;

    localparam int BHT_IDX_W   = 10;
    localparam int BHT_HIST_W  = 10;
    localparam int BHT_ENTRIES = 1 << BHT_IDX_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CLEAR = 2'd2
    } bht_upd_state_e;

    typedef struct packed {
        logic [BHT_IDX_W-1:0] index;
        logic                 brdir;
    } bht_upd_entry_t;

    function automatic bht_upd_entry_t make_entry(input logic [BHT_IDX_W-1:0] index,
                                                  input logic                 brdir);
        bht_upd_entry_t e;
        e.index = index;
        e.brdir = brdir;
        return e;
    endfunction

endpackage

// File: rtl/bht_upd_fifo.sv
// Two-write / one-read circular FIFO of committed branch records; port 0 is
// the older slot and is always written ahead of port 1.
module bht_upd_fifo
    import bht_update_ctrl_pkg::*;
#(
    parameter int QDEPTH = 8
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        i_push0,
    input  bht_upd_entry_t              i_data0,
    input  logic                        i_push1,
    input  bht_upd_entry_t              i_data1,
    input  logic                        i_pop,
    output bht_upd_entry_t              o_head,
    output logic [$clog2(QDEPTH):0]     o_count
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;

    bht_upd_entry_t     r_mem [QDEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [PTR_W-1:0]   w_wr_ptr1;
    logic [CNT_W-1:0]   w_npush;

    assign w_wr_ptr1 = r_wr_ptr + {{(PTR_W-1){1'b0}}, 1'b1};
    assign w_npush   = CNT_W'(i_push0) + CNT_W'(i_push1);
    assign o_head    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Storage write; a lone push1 lands in the current tail slot.
    always_ff @(posedge clock) begin
        if (i_push0) begin
            r_mem[r_wr_ptr] <= i_data0;
        end
        if (i_push1) begin
            r_mem[i_push0 ? w_wr_ptr1 : r_wr_ptr] <= i_data1;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(w_npush);
            r_rd_ptr <= r_rd_ptr + PTR_W'(i_pop);
            r_count  <= r_count + w_npush - CNT_W'(i_pop);
        end
    end

endmodule

// File: rtl/bht_update_ctrl.sv
// Scheduler for the single shift-in port of the local BHT: queues retired
// branch outcomes, issues one shift per cycle and sequences full-table clears.
module bht_update_ctrl
    import bht_update_ctrl_pkg::*;
#(
    parameter int QDEPTH = 8,
    parameter int IDX_W  = BHT_IDX_W,
    parameter int HIST_W = BHT_HIST_W
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             cm0_valid_i,
    input  logic [IDX_W-1:0] cm0_index_i,
    input  logic             cm0_brdir_i,
    input  logic             cm1_valid_i,
    input  logic [IDX_W-1:0] cm1_index_i,
    input  logic             cm1_brdir_i,
    output logic             cm_ready_o,
    input  logic             clr_req_i,
    output logic             clr_busy_o,
    output logic             clr_done_o,
    output logic             ovf_err_o,
    output logic [IDX_W-1:0] bht_wt_index_o,
    output logic             bht_cm_brdir_o,
    output logic             bht_cm_brdir_se_o
);

    localparam int               CNT_W     = $clog2(QDEPTH) + 1;
    localparam int               HC_W      = $clog2(HIST_W);
    localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(QDEPTH - 2);
    localparam logic [HC_W-1:0]  HC_LAST   = HC_W'(HIST_W - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = {IDX_W{1'b1}};

    bht_upd_state_e   r_state, w_state_nxt;
    logic [IDX_W-1:0] r_clr_idx;
    logic [HC_W-1:0]  r_clr_cnt;
    logic [IDX_W-1:0] r_wt_index, w_idx_nxt;
    logic             r_brdir, w_dir_nxt;
    logic             r_se, w_se_nxt;
    logic             r_done;
    logic             r_ovf;
    logic             w_ready, w_push0, w_push1, w_drop, w_pop, w_clr_last;
    logic [CNT_W-1:0] w_count;
    bht_upd_entry_t   w_head;

    bht_upd_fifo #(.QDEPTH(QDEPTH)) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .i_push0 (w_push0),
        .i_data0 (make_entry(cm0_index_i, cm0_brdir_i)),
        .i_push1 (w_push1),
        .i_data1 (make_entry(cm1_index_i, cm1_brdir_i)),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count)
    );

    // FSM state register.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a clear request outside IDLE is simply not looked at.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (clr_req_i)          w_state_nxt = ST_DRAIN; else w_state_nxt = ST_IDLE;
            ST_DRAIN: if (w_count == '0)      w_state_nxt = ST_CLEAR; else w_state_nxt = ST_DRAIN;
            ST_CLEAR: if (w_clr_last)         w_state_nxt = ST_IDLE;  else w_state_nxt = ST_CLEAR;
            default:                          w_state_nxt = ST_IDLE;
        endcase
    end

    // Queue handshake and next values of the write-port registers.
    always_comb begin
        w_ready    = (r_state == ST_IDLE) && (w_count <= READY_MAX);
        w_push0    = cm0_valid_i & w_ready;
        w_push1    = cm1_valid_i & w_ready;
        w_drop     = (cm0_valid_i | cm1_valid_i) & ~w_ready;
        w_pop      = ((r_state == ST_IDLE) || (r_state == ST_DRAIN)) && (w_count != '0);
        w_clr_last = (r_state == ST_CLEAR) && (r_clr_idx == IDX_LAST) && (r_clr_cnt == HC_LAST);
        w_se_nxt   = 1'b0;
        w_idx_nxt  = r_wt_index;
        w_dir_nxt  = r_brdir;
        if (w_pop) begin
            w_se_nxt  = 1'b1;
            w_idx_nxt = w_head.index;
            w_dir_nxt = w_head.brdir;
        end else if (r_state == ST_CLEAR) begin
            w_se_nxt  = 1'b1;
            w_idx_nxt = r_clr_idx;
            w_dir_nxt = 1'b0;
        end else begin
            w_se_nxt  = 1'b0;
        end
    end

    // Clear walk: HIST_W zero shifts per entry, then advance to the next index.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_clr_idx <= '0;
            r_clr_cnt <= '0;
        end else if (r_state == ST_CLEAR) begin
            if (r_clr_cnt == HC_LAST) begin
                r_clr_cnt <= '0;
                r_clr_idx <= r_clr_idx + {{(IDX_W-1){1'b0}}, 1'b1};
            end else begin
                r_clr_cnt <= r_clr_cnt + {{(HC_W-1){1'b0}}, 1'b1};
            end
        end else begin
            r_clr_idx <= '0;
            r_clr_cnt <= '0;
        end
    end

    // Registered write port, done pulse and sticky overflow flag.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_se       <= 1'b0;
            r_wt_index <= '0;
            r_brdir    <= 1'b0;
            r_done     <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_se       <= w_se_nxt;
            r_wt_index <= w_idx_nxt;
            r_brdir    <= w_dir_nxt;
            r_done     <= w_clr_last;
            r_ovf      <= r_ovf | w_drop;
        end
    end

    assign cm_ready_o        = w_ready;
    assign clr_busy_o        = (r_state != ST_IDLE) | r_done;
    assign clr_done_o        = r_done;
    assign ovf_err_o         = r_ovf;
    assign bht_wt_index_o    = r_wt_index;
    assign bht_cm_brdir_o    = r_brdir;
    assign bht_cm_brdir_se_o = r_se;

endmodule

// File: tb/tb_bht_update_ctrl.sv
// Directed self-checking bench for bht_update_ctrl at default geometry.
module tb_bht_update_ctrl;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       cm0_valid_i, cm0_brdir_i, cm1_valid_i, cm1_brdir_i;
    logic [9:0] cm0_index_i, cm1_index_i;
    logic       cm_ready_o, clr_req_i, clr_busy_o, clr_done_o, ovf_err_o;
    logic [9:0] bht_wt_index_o;
    logic       bht_cm_brdir_o, bht_cm_brdir_se_o;

    int n_chk = 0;
    int n_err = 0;
    logic [10:0] log_q[$];

    always #5 clock = ~clock;

    bht_update_ctrl dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .cm0_valid_i       (cm0_valid_i),
        .cm0_index_i       (cm0_index_i),
        .cm0_brdir_i       (cm0_brdir_i),
        .cm1_valid_i       (cm1_valid_i),
        .cm1_index_i       (cm1_index_i),
        .cm1_brdir_i       (cm1_brdir_i),
        .cm_ready_o        (cm_ready_o),
        .clr_req_i         (clr_req_i),
        .clr_busy_o        (clr_busy_o),
        .clr_done_o        (clr_done_o),
        .ovf_err_o         (ovf_err_o),
        .bht_wt_index_o    (bht_wt_index_o),
        .bht_cm_brdir_o    (bht_cm_brdir_o),
        .bht_cm_brdir_se_o (bht_cm_brdir_se_o)
    );

    // Record every issued shift as {index, brdir}.
    always @(posedge clock) begin
        #1;
        if (reset_n && bht_cm_brdir_se_o) log_q.push_back({bht_wt_index_o, bht_cm_brdir_o});
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        cm0_valid_i = 1'b0; cm0_index_i = 10'h000; cm0_brdir_i = 1'b0;
        cm1_valid_i = 1'b0; cm1_index_i = 10'h000; cm1_brdir_i = 1'b0;
        clr_req_i   = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_se"},    32'(bht_cm_brdir_se_o), 32'd0);
        check_eq({tag, "_idx"},   32'(bht_wt_index_o),    32'd0);
        check_eq({tag, "_dir"},   32'(bht_cm_brdir_o),    32'd0);
        check_eq({tag, "_ovf"},   32'(ovf_err_o),         32'd0);
        check_eq({tag, "_busy"},  32'(clr_busy_o),        32'd0);
        check_eq({tag, "_done"},  32'(clr_done_o),        32'd0);
        check_eq({tag, "_ready"}, 32'(cm_ready_o),        32'd1);
    endtask

    initial begin
        int ndone;
        int nbad;
        bit found;
        logic [10:0] exp_e;

        idle_inputs();
        do_reset();
        check_reset_outputs("rst");

        // Single commit: visible one edge after the enqueue edge
        cm0_valid_i = 1'b1; cm0_index_i = 10'h2A5; cm0_brdir_i = 1'b1;
        tick();
        idle_inputs();
        check_eq("single_early_se", 32'(bht_cm_brdir_se_o), 32'd0);
        tick();
        check_eq("single_se",  32'(bht_cm_brdir_se_o), 32'd1);
        check_eq("single_idx", 32'(bht_wt_index_o),    32'h2A5);
        check_eq("single_dir", 32'(bht_cm_brdir_o),    32'd1);
        tick();
        check_eq("single_se_off",   32'(bht_cm_brdir_se_o), 32'd0);
        check_eq("single_idx_hold", 32'(bht_wt_index_o),    32'h2A5);

        // Dual commit: older first
        cm0_valid_i = 1'b1; cm0_index_i = 10'h001; cm0_brdir_i = 1'b1;
        cm1_valid_i = 1'b1; cm1_index_i = 10'h001; cm1_brdir_i = 1'b0;
        tick();
        idle_inputs();
        tick();
        check_eq("dual0_se",  32'(bht_cm_brdir_se_o), 32'd1);
        check_eq("dual0_idx", 32'(bht_wt_index_o),    32'h001);
        check_eq("dual0_dir", 32'(bht_cm_brdir_o),    32'd1);
        tick();
        check_eq("dual1_se",  32'(bht_cm_brdir_se_o), 32'd1);
        check_eq("dual1_dir", 32'(bht_cm_brdir_o),    32'd0);
        tick();
        check_eq("dual_empty_se", 32'(bht_cm_brdir_se_o), 32'd0);
        check_eq("dual_ready",    32'(cm_ready_o),        32'd1);

        // Fill: count goes 2,3,4,5,6,7 over six dual-commit edges
        log_q.delete();
        for (int k = 0; k < 6; k++) begin
            cm0_valid_i = 1'b1; cm0_index_i = 10'(10'h100 + 2*k);     cm0_brdir_i = 1'b1;
            cm1_valid_i = 1'b1; cm1_index_i = 10'(10'h100 + 2*k + 1); cm1_brdir_i = 1'b0;
            tick();
            if (k == 4) check_eq("fill_ready_at6", 32'(cm_ready_o), 32'd1);
        end
        idle_inputs();
        check_eq("fill_ready_at7", 32'(cm_ready_o), 32'd0);
        check_eq("fill_ovf_pre",   32'(ovf_err_o),  32'd0);
        cm0_valid_i = 1'b1; cm0_index_i = 10'h3FF; cm0_brdir_i = 1'b1;
        tick();
        idle_inputs();
        check_eq("fill_ovf_set", 32'(ovf_err_o), 32'd1);
        for (int i = 0; i < 16; i++) tick();
        check_eq("fill_issued", 32'(log_q.size()), 32'd12);
        for (int n = 0; n < 12 && n < log_q.size(); n++) begin
            exp_e = {10'(10'h100 + n), ((n % 2) == 0) ? 1'b1 : 1'b0};
            check_eq($sformatf("fill_order%0d", n), 32'(log_q[n]), 32'(exp_e));
        end
        check_eq("fill_ovf_sticky", 32'(ovf_err_o), 32'd1);
        check_eq("fill_ready_back", 32'(cm_ready_o), 32'd1);

        // Clear with three queued entries, dropped commit and second request mid-clear
        do_reset();
        log_q.delete();
        cm0_valid_i = 1'b1; cm0_index_i = 10'h00A; cm0_brdir_i = 1'b1;
        cm1_valid_i = 1'b1; cm1_index_i = 10'h00B; cm1_brdir_i = 1'b0;
        tick();
        idle_inputs();
        cm0_valid_i = 1'b1; cm0_index_i = 10'h00C; cm0_brdir_i = 1'b1;
        tick();
        idle_inputs();
        clr_req_i = 1'b1;
        tick();
        idle_inputs();
        check_eq("clr_busy", 32'(clr_busy_o), 32'd1);
        check_eq("clr_ready_low", 32'(cm_ready_o), 32'd0);
        ndone = 0;
        for (int i = 0; i < 10300; i++) begin
            if (i == 100) begin
                check_eq("clr_ovf_before", 32'(ovf_err_o), 32'd0);
                cm0_valid_i = 1'b1; cm0_index_i = 10'h155; cm0_brdir_i = 1'b1;
                clr_req_i   = 1'b1;
            end
            tick();
            if (i == 100) begin
                idle_inputs();
                check_eq("clr_ovf_drop", 32'(ovf_err_o), 32'd1);
            end
            if (clr_done_o) begin
                ndone++;
                check_eq("clr_done_ready", 32'(cm_ready_o), 32'd1);
                check_eq("clr_done_busy",  32'(clr_busy_o), 32'd1);
            end
        end
        check_eq("clr_done_once", 32'(ndone), 32'd1);
        check_eq("clr_busy_end",  32'(clr_busy_o), 32'd0);
        check_eq("clr_log_size",  32'(log_q.size()), 32'd10243);
        if (log_q.size() >= 3) begin
            check_eq("clr_q0", 32'(log_q[0]), 32'({10'h00A, 1'b1}));
            check_eq("clr_q1", 32'(log_q[1]), 32'({10'h00B, 1'b0}));
            check_eq("clr_q2", 32'(log_q[2]), 32'({10'h00C, 1'b1}));
        end
        nbad = 0;
        for (int j = 0; j < 10240 && (j + 3) < log_q.size(); j++) begin
            exp_e = {10'(j / 10), 1'b0};
            if (log_q[j + 3] !== exp_e) nbad++;
        end
        check_eq("clr_walk_bad", 32'(nbad), 32'd0);

        // Reset in the middle of a clear at index 0x100
        clr_req_i = 1'b1;
        tick();
        idle_inputs();
        found = 1'b0;
        for (int i = 0; i < 5000 && !found; i++) begin
            tick();
            if (bht_cm_brdir_se_o && bht_wt_index_o == 10'h100) found = 1'b1;
        end
        check_eq("mid_found", 32'(found), 32'd1);
        reset_n = 1'b0;
        tick();
        check_reset_outputs("mid_rst");
        reset_n = 1'b1;
        ndone = 0;
        nbad  = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (clr_done_o) ndone++;
            if (bht_cm_brdir_se_o) nbad++;
        end
        check_eq("mid_no_done", 32'(ndone), 32'd0);
        check_eq("mid_no_se",   32'(nbad),  32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
